// File: rtl/debounce_scheduler_pkg.sv
// Shared definitions for the debounce scheduler: FSM state encoding,
// default debounce limit and an elaboration-time ceil(log2) helper.
package debounce_pkg;

    // Scheduler FSM states: waiting for a mismatch, counting stable cycles,
    // and the single cycle in which a debounced level is flipped.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_COMMIT = 2'd2
    } db_state_e;

    // 10 ms at 25 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 32'd250000;
    localparam int unsigned DEFAULT_NUM_CH         = 32'd4;
    localparam int unsigned DEFAULT_CNT_W          = 32'd18;

    // Number of bits needed to index 'value' items (minimum 1).
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned bits;
        bits = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                bits = i + 32'd1;
            end else begin
                bits = bits;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/debounce_scheduler_rr_select.sv
// rr_select: combinational rotate-priority picker. Returns the first set
// request bit found when scanning i_ptr, i_ptr+1, ... (mod N). Reusable by
// any round-robin arbiter that keeps its own pointer.
module rr_select
    import debounce_pkg::*;
#(
    parameter  int unsigned N     = 32'd4,
    localparam int unsigned IDX_W = clog2_f(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [31:0] pos_s;

    // Scan from the farthest offset down to offset 0 so the nearest request
    // to the pointer is the last one written and therefore wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        pos_s   = 32'd0;
        for (int unsigned k = N; k > 32'd0; k--) begin
            pos_s = (32'(i_ptr) + k - 32'd1) % N;
            if (i_req[pos_s[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = pos_s[IDX_W-1:0];
            end else begin
                o_found = o_found;
                o_idx   = o_idx;
            end
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces NUM_CH raw switch inputs using a single
// shared stability counter, granted round-robin to the next channel whose
// raw level differs from its debounced level. Emits per-channel debounced
// levels and one-cycle press pulses on debounced 0->1 transitions.
//
// Optional feature macro: DEBOUNCE_SCHED_SYNC_EN
//   defined   - each i_switch bit passes through a 2-flop synchroniser
//               (reset to 0), adding 2 cycles of latency.
//   undefined - i_switch is used directly and must already be synchronous
//               to i_Clk.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter  int unsigned NUM_CH         = DEFAULT_NUM_CH,
    parameter  int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter  int unsigned CNT_W          = DEFAULT_CNT_W,
    localparam int unsigned IDX_W          = clog2_f(NUM_CH)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_switch,
    output logic [NUM_CH-1:0] o_state,
    output logic [NUM_CH-1:0] o_press_pulse,
    output logic              o_busy,
    output logic [IDX_W-1:0]  o_grant_ch
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 32'd1);
    localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(NUM_CH - 32'd1);

    logic [NUM_CH-1:0] raw_s;
    logic [NUM_CH-1:0] mismatch_s;
    logic              found_s;
    logic [IDX_W-1:0]  pick_s;
    logic [IDX_W-1:0]  next_ptr_s;

    db_state_e         fsm_q, fsm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic              busy_q, busy_d;

`ifdef DEBOUNCE_SCHED_SYNC_EN
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    // Two-stage synchroniser bringing asynchronous switch inputs into i_Clk.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_switch;
            sync2_q <= sync1_q;
        end
    end

    assign raw_s = sync2_q;
`else
    assign raw_s = i_switch;
`endif

    // A channel needs service while its raw level disagrees with the
    // accepted level; a bounce back clears the request on its own.
    assign mismatch_s = raw_s ^ level_q;

    rr_select #(
        .N (NUM_CH)
    ) u_rr_select (
        .i_req   (mismatch_s),
        .i_ptr   (ptr_q),
        .o_found (found_s),
        .o_idx   (pick_s)
    );

    // The scan resumes one past the channel that last held the counter.
    assign next_ptr_s = (grant_q == CH_LAST) ? '0 : (grant_q + IDX_W'(1));

    // Next-state logic for the scheduler, shared counter and output levels.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        level_d = level_q;
        pulse_d = '0;

        case (fsm_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d = pick_s;
                    cnt_d   = '0;
                    fsm_d   = ST_COUNT;
                end else begin
                    fsm_d   = ST_IDLE;
                end
            end

            ST_COUNT: begin
                // Only the granted channel is watched; others wait their turn.
                if (!mismatch_s[grant_q]) begin
                    fsm_d = ST_IDLE;
                    cnt_d = '0;
                    ptr_d = next_ptr_s;
                end else if (cnt_q == CNT_LAST) begin
                    fsm_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_COMMIT: begin
                level_d[grant_q] = ~level_q[grant_q];
                pulse_d[grant_q] = ~level_q[grant_q];
                ptr_d            = next_ptr_s;
                cnt_d            = '0;
                fsm_d            = ST_IDLE;
            end

            default: begin
                fsm_d = ST_IDLE;
                cnt_d = '0;
            end
        endcase

        busy_d = (fsm_d != ST_IDLE);
    end

    // State and registered outputs; async reset drops everything, no pulse.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign o_state       = level_q;
    assign o_press_pulse = pulse_q;
    assign o_busy        = busy_q;
    assign o_grant_ch    = grant_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Testbench for debounce_scheduler (NUM_CH=4, DEBOUNCE_LIMIT=8). A
// behavioural model tracks which channel holds the counter and how many
// stable cycles it has accumulated; a compare process checks the DUT against
// it every cycle, and directed scenarios pin exact latencies with literals.
module tb_debounce_scheduler;

    localparam int NCH   = 4;
    localparam int LIMIT = 8;
`ifdef DEBOUNCE_SCHED_SYNC_EN
    localparam int EX = 2;
`else
    localparam int EX = 0;
`endif

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] sw;
    logic [NCH-1:0] o_state;
    logic [NCH-1:0] o_press_pulse;
    logic           o_busy;
    logic [1:0]     o_grant_ch;

    int checks;
    int errors;

    debounce_scheduler #(
        .NUM_CH         (NCH),
        .DEBOUNCE_LIMIT (LIMIT),
        .CNT_W          (4)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_switch      (sw),
        .o_state       (o_state),
        .o_press_pulse (o_press_pulse),
        .o_busy        (o_busy),
        .o_grant_ch    (o_grant_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NCH-1:0] m_state, m_pulse, m_s1, m_s2;
    logic           m_busy, m_commit;
    int             m_grant, m_ptr, m_stable;

    always @(posedge clk or negedge rst_n) begin : model
        logic [NCH-1:0] raw, n_state, n_pulse;
        logic           n_busy, n_commit, found;
        int             n_grant, n_ptr, n_stable, idx;
        if (!rst_n) begin
            m_state <= '0; m_pulse <= '0; m_busy <= 1'b0; m_commit <= 1'b0;
            m_grant <= 0;  m_ptr <= 0;    m_stable <= 0;
            m_s1 <= '0;    m_s2 <= '0;
        end else begin
            raw = (EX != 0) ? m_s2 : sw;
            n_state = m_state; n_pulse = '0; n_busy = m_busy; n_commit = 1'b0;
            n_grant = m_grant; n_ptr = m_ptr; n_stable = m_stable; found = 1'b0;
            if (m_commit) begin
                n_state[m_grant] = ~m_state[m_grant];
                n_pulse[m_grant] = n_state[m_grant];
                n_ptr  = (m_grant + 1) % NCH;
                n_busy = 1'b0;
            end else if (m_busy) begin
                if (raw[m_grant] == m_state[m_grant]) begin
                    n_busy = 1'b0;
                    n_ptr  = (m_grant + 1) % NCH;
                end else begin
                    n_stable = m_stable + 1;
                    if (n_stable == LIMIT) n_commit = 1'b1;
                end
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    idx = (m_ptr + k) % NCH;
                    if (!found && (raw[idx] != m_state[idx])) begin
                        found   = 1'b1;
                        n_grant = idx;
                    end
                end
                if (found) begin
                    n_busy   = 1'b1;
                    n_stable = 0;
                end
            end
            m_state <= n_state; m_pulse <= n_pulse; m_busy <= n_busy;
            m_commit <= n_commit; m_grant <= n_grant; m_ptr <= n_ptr;
            m_stable <= n_stable; m_s1 <= sw; m_s2 <= m_s1;
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        chk("model_state", 32'(o_state), 32'(m_state));
        chk("model_pulse", 32'(o_press_pulse), 32'(m_pulse));
        chk("model_busy", 32'(o_busy), 32'(m_busy));
        if (m_busy) chk("model_grant", 32'(o_grant_ch), 32'(m_grant));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sw     = 4'hF;

        // Reset values while reset is held with all inputs high.
        #3;
        chk("rst_state", 32'(o_state), 32'h0);
        chk("rst_pulse", 32'(o_press_pulse), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1 + EX);
        chk("first_grant_busy", 32'(o_busy), 32'h1);
        chk("first_grant_ch", 32'(o_grant_ch), 32'h0);
        tick(50);
        chk("all_pressed", 32'(o_state), 32'hF);
        sw = 4'h0;
        tick(50);
        chk("all_released", 32'(o_state), 32'h0);

        // Contention: ch0 and ch3 together, pointer at 0.
        sw = 4'b1001;
        tick(9 + EX);
        chk("cont_t9_state", 32'(o_state), 32'h0);
        tick(1);
        chk("cont_t10_state", 32'(o_state), 32'h1);
        chk("cont_t10_pulse", 32'(o_press_pulse), 32'h1);
        tick(1);
        chk("cont_t11_pulse", 32'(o_press_pulse), 32'h0);
        tick(8);
        chk("cont_t19_state", 32'(o_state), 32'h1);
        tick(1);
        chk("cont_t20_state", 32'(o_state), 32'h9);
        chk("cont_t20_pulse", 32'(o_press_pulse), 32'h8);
        sw = 4'h0;
        tick(30);

        // Single press on ch2.
        sw = 4'b0100;
        tick(9 + EX);
        chk("press_t9_state", 32'(o_state), 32'h0);
        chk("press_t9_busy", 32'(o_busy), 32'h1);
        tick(1);
        chk("press_t10_state", 32'(o_state), 32'h4);
        chk("press_t10_pulse", 32'(o_press_pulse), 32'h4);
        tick(1);
        chk("press_t11_pulse", 32'(o_press_pulse), 32'h0);
        sw = 4'h0;
        tick(15);
        chk("press_released", 32'(o_state), 32'h0);

        // Bounce on ch1: high 5 cycles then low; scan must resume from ch2.
        sw = 4'b0010;
        tick(5);
        sw = 4'b0000;
        tick(4 + EX);
        chk("bounce_busy", 32'(o_busy), 32'h0);
        chk("bounce_state", 32'(o_state), 32'h0);
        sw = 4'b0101;
        tick(1 + EX);
        chk("after_bounce_grant", 32'(o_grant_ch), 32'h2);
        chk("after_bounce_busy", 32'(o_busy), 32'h1);
        tick(25);
        chk("after_bounce_state", 32'(o_state), 32'h5);

        // Async reset mid-count on ch1 (cnt=4), then full re-debounce.
        sw = 4'b0111;
        tick(5 + EX);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(o_state), 32'h0);
        chk("async_rst_busy", 32'(o_busy), 32'h0);
        chk("async_rst_pulse", 32'(o_press_pulse), 32'h0);
        chk("async_rst_grant", 32'(o_grant_ch), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(9 + EX);
        chk("rerun_t9_state", 32'(o_state), 32'h0);
        tick(1);
        chk("rerun_t10_state", 32'(o_state), 32'h1);
        chk("rerun_t10_pulse", 32'(o_press_pulse), 32'h1);

        // Randomised phase: random levels held for random durations so both
        // bounces and commits occur, with occasional asynchronous resets.
        for (int it = 0; it < 400; it++) begin
            sw = 4'($urandom_range(0, 15));
            tick($urandom_range(1, 30));
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #4;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
